// File: rtl/mp64_alu_wide_if.sv
// Request, response and ALU-drive signals of the 128-bit sequencer.
// The slave view belongs to the sequencer; the master view is its core/ALU side.
interface mp64_alu_wide_if;
  logic         req_valid;
  logic         req_ready;
  logic [1:0]   req_op;
  logic [127:0] req_a;
  logic [127:0] req_b;
  logic [7:0]   req_flags;

  logic         rsp_valid;
  logic         rsp_ready;
  logic [127:0] rsp_result;
  logic [7:0]   rsp_flags;

  logic [3:0]   alu_op;
  logic [63:0]  alu_a;
  logic [63:0]  alu_b;
  logic [7:0]   alu_flags_in;
  logic [63:0]  alu_result;
  logic [7:0]   alu_flags_out;

  modport master (
    output req_valid, req_op, req_a, req_b, req_flags, rsp_ready,
           alu_result, alu_flags_out,
    input  req_ready, rsp_valid, rsp_result, rsp_flags,
           alu_op, alu_a, alu_b, alu_flags_in
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_flags, rsp_ready,
           alu_result, alu_flags_out,
    output req_ready, rsp_valid, rsp_result, rsp_flags,
           alu_op, alu_a, alu_b, alu_flags_in
  );
endinterface

// File: rtl/mp64_alu_wide.sv
// 128-bit ADD/SUB/CMP/NEG sequencer: two passes through the shared 64-bit ALU,
// low word then high word with the carry chained through the flags byte.
module mp64_alu_wide (
  input  logic              clk,
  input  logic              rst,
  mp64_alu_wide_if.slave    bus
);

  // state | meaning
  // IDLE  | waiting for a request, ALU parked on MOV 0
  // LO    | low-word pass on the ALU
  // HI    | high-word pass, carry taken from the LO flags
  // DONE  | response held until rsp_ready
  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_CMP = 2'd2;
  localparam logic [1:0] OP_NEG = 2'd3;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_MOV = 4'd5;
  localparam logic [3:0] ALU_ADC = 4'd12;
  localparam logic [3:0] ALU_SBB = 4'd13;

  state_t state, state_d;

  logic [1:0]   op_q, op_d;
  logic [63:0]  a_hi_q, a_hi_d;
  logic [63:0]  b_hi_q, b_hi_d;
  logic [2:0]   sig_q, sig_d;
  logic [63:0]  r_lo_q, r_lo_d;
  logic         lo_z_q, lo_z_d;
  logic         lo_p_q, lo_p_d;
  logic         rsp_valid_q, rsp_valid_d;
  logic [127:0] rsp_result_q, rsp_result_d;
  logic [7:0]   rsp_flags_q, rsp_flags_d;
  logic [3:0]   alu_op_q, alu_op_d;
  logic [63:0]  alu_a_q, alu_a_d;
  logic [63:0]  alu_b_q, alu_b_d;
  logic [7:0]   alu_fin_q, alu_fin_d;

  logic [63:0]  hi_a;
  logic         is_sub;
  logic         hi_c;
  logic         mrg_z;
  logic         mrg_c;
  logic         mrg_v;
  logic         mrg_g;
  logic [7:0]   mrg_flags;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (bus.req_valid) state_d = LO;
      LO:      state_d = HI;
      HI:      state_d = DONE;
      DONE:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NEG is computed as 0 - b, so its A operand is zero in both passes.
  assign hi_a   = (op_q == OP_NEG) ? 64'd0 : a_hi_q;
  assign is_sub = (op_q == OP_SUB) || (op_q == OP_CMP);
  assign hi_c   = bus.alu_flags_out[1];
  assign mrg_z  = lo_z_q & bus.alu_flags_out[0];
  assign mrg_c  = (op_q == OP_NEG) ? ~hi_c : hi_c;
  // SBB leaves V untouched, so signed overflow of the subtract forms is derived here.
  assign mrg_v  = (op_q == OP_ADD) ? bus.alu_flags_out[3]
                : ((hi_a[63] ^ b_hi_q[63]) & (hi_a[63] ^ bus.alu_result[63]));
  assign mrg_g  = is_sub ? (hi_c & ~mrg_z) : sig_q[0];
  assign mrg_flags = {sig_q[2:1], mrg_g, lo_p_q, mrg_v, bus.alu_result[63], mrg_c, mrg_z};

  always_comb begin
    op_d         = op_q;
    a_hi_d       = a_hi_q;
    b_hi_d       = b_hi_q;
    sig_d        = sig_q;
    r_lo_d       = r_lo_q;
    lo_z_d       = lo_z_q;
    lo_p_d       = lo_p_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;
    alu_op_d     = ALU_MOV;
    alu_a_d      = 64'd0;
    alu_b_d      = 64'd0;
    alu_fin_d    = 8'd0;
    unique case (state)
      IDLE: begin
        if (bus.req_valid) begin
          op_d      = bus.req_op;
          a_hi_d    = bus.req_a[127:64];
          b_hi_d    = bus.req_b[127:64];
          sig_d     = bus.req_flags[7:5];
          alu_op_d  = (bus.req_op == OP_ADD) ? ALU_ADD : ALU_SUB;
          alu_a_d   = (bus.req_op == OP_NEG) ? 64'd0 : bus.req_a[63:0];
          alu_b_d   = bus.req_b[63:0];
          alu_fin_d = bus.req_flags;
        end
      end
      LO: begin
        r_lo_d    = bus.alu_result;
        lo_z_d    = bus.alu_flags_out[0];
        lo_p_d    = bus.alu_flags_out[4];
        alu_op_d  = (op_q == OP_ADD) ? ALU_ADC : ALU_SBB;
        alu_a_d   = hi_a;
        alu_b_d   = b_hi_q;
        alu_fin_d = bus.alu_flags_out;
      end
      HI: begin
        rsp_valid_d  = 1'b1;
        rsp_result_d = (op_q == OP_CMP) ? 128'd0 : {bus.alu_result, r_lo_q};
        rsp_flags_d  = mrg_flags;
      end
      DONE: begin
        if (bus.rsp_ready) rsp_valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q         <= OP_ADD;
      a_hi_q       <= 64'd0;
      b_hi_q       <= 64'd0;
      sig_q        <= 3'd0;
      r_lo_q       <= 64'd0;
      lo_z_q       <= 1'b0;
      lo_p_q       <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= 128'd0;
      rsp_flags_q  <= 8'd0;
      alu_op_q     <= ALU_MOV;
      alu_a_q      <= 64'd0;
      alu_b_q      <= 64'd0;
      alu_fin_q    <= 8'd0;
    end else begin
      op_q         <= op_d;
      a_hi_q       <= a_hi_d;
      b_hi_q       <= b_hi_d;
      sig_q        <= sig_d;
      r_lo_q       <= r_lo_d;
      lo_z_q       <= lo_z_d;
      lo_p_q       <= lo_p_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
      alu_op_q     <= alu_op_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_fin_q    <= alu_fin_d;
    end
  end

  assign bus.req_ready    = (state == IDLE) && !rst;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_result   = rsp_result_q;
  assign bus.rsp_flags    = rsp_flags_q;
  assign bus.alu_op       = alu_op_q;
  assign bus.alu_a        = alu_a_q;
  assign bus.alu_b        = alu_b_q;
  assign bus.alu_flags_in = alu_fin_q;

endmodule

// File: tb/tb_mp64_alu_wide.sv
// Bench for mp64_alu_wide: behavioural 64-bit ALU on the ALU side, a 128-bit
// reference model feeding a scoreboard queue on the request side.
module tb_mp64_alu_wide;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_CMP = 2'd2;
  localparam logic [1:0] OP_NEG = 2'd3;

  typedef struct {
    logic [127:0] result;
    logic [7:0]   flags;
  } exp_t;

  logic clk;
  logic rst;
  int   tests;
  int   fails;
  exp_t sb[$];

  mp64_alu_wide_if bus();

  mp64_alu_wide dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared 64-bit ALU: C is carry-out for ADD/ADC and "no borrow" for SUB/SBB.
  logic [64:0] alu_sum;
  logic [63:0] alu_r;
  logic [7:0]  alu_fo;
  always_comb begin
    alu_sum = 65'd0;
    alu_fo  = bus.alu_flags_in;
    case (bus.alu_op)
      4'd0:    alu_sum = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
      4'd1:    alu_sum = {1'b0, bus.alu_a} + {1'b0, ~bus.alu_b} + 65'd1;
      4'd12:   alu_sum = {1'b0, bus.alu_a} + {1'b0, bus.alu_b} + {64'd0, bus.alu_flags_in[1]};
      4'd13:   alu_sum = {1'b0, bus.alu_a} + {1'b0, ~bus.alu_b} + {64'd0, bus.alu_flags_in[1]};
      default: alu_sum = {bus.alu_flags_in[1], bus.alu_b};
    endcase
    alu_r     = alu_sum[63:0];
    alu_fo[1] = alu_sum[64];
    alu_fo[0] = (alu_r == 64'd0);
    alu_fo[2] = alu_r[63];
    alu_fo[4] = ~^alu_r[7:0];
    if (bus.alu_op == 4'd0 || bus.alu_op == 4'd12)
      alu_fo[3] = (bus.alu_a[63] == bus.alu_b[63]) && (alu_r[63] != bus.alu_a[63]);
    else if (bus.alu_op == 4'd1)
      alu_fo[3] = (bus.alu_a[63] ^ bus.alu_b[63]) & (bus.alu_a[63] ^ alu_r[63]);
    bus.alu_result    = alu_r;
    bus.alu_flags_out = alu_fo;
  end

  function automatic exp_t ref_model(input logic [1:0] op, input logic [127:0] a,
                                     input logic [127:0] b, input logic [7:0] f);
    exp_t e;
    logic [128:0] full;
    logic [127:0] r;
    logic c, v, g, z;
    full = 129'd0;
    g = f[5];
    if (op == OP_ADD) begin
      full = {1'b0, a} + {1'b0, b};
      r = full[127:0];
      c = full[128];
      v = (a[127] == b[127]) && (r[127] != a[127]);
    end else if (op == OP_NEG) begin
      r = 128'd0 - b;
      c = (b != 128'd0);
      v = b[127] & r[127];
    end else begin
      r = a - b;
      c = (a >= b);
      v = (a[127] ^ b[127]) & (a[127] ^ r[127]);
    end
    z = (r == 128'd0);
    if (op == OP_SUB || op == OP_CMP) g = c & ~z;
    e.flags  = {f[7], f[6], g, ~^r[7:0], v, r[127], c, z};
    e.result = (op == OP_CMP) ? 128'd0 : r;
    return e;
  endfunction

  task automatic run_txn(input logic [1:0] op, input logic [127:0] a, input logic [127:0] b,
                         input logic [7:0] f, input int hold,
                         output logic [127:0] res, output logic [7:0] flg);
    exp_t e;
    int lat;
    sb.push_back(ref_model(op, a, b, f));
    res = 128'd0;
    flg = 8'd0;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    tests++;
    if (bus.req_ready !== 1'b1) begin
      fails++; $display("FAIL req_ready_idle got %b want 1", bus.req_ready);
    end
    bus.req_valid = 1'b1; bus.req_op = op; bus.req_a = a; bus.req_b = b; bus.req_flags = f;
    @(posedge clk); #1;
    // scramble the request after acceptance; the block must have latched it
    bus.req_valid = 1'b0; bus.req_op = ~op; bus.req_a = ~a; bus.req_b = ~b; bus.req_flags = ~f;
    @(negedge clk);
    lat = 1;
    tests++;
    if (bus.alu_op !== ((op == OP_ADD) ? 4'd0 : 4'd1) ||
        bus.alu_a !== ((op == OP_NEG) ? 64'd0 : a[63:0]) ||
        bus.alu_b !== b[63:0] || bus.alu_flags_in !== f) begin
      fails++; $display("FAIL lo_drive got op=%0d a=%h b=%h fi=%h", bus.alu_op, bus.alu_a, bus.alu_b, bus.alu_flags_in);
    end
    tests++;
    if (bus.req_ready !== 1'b0 || bus.rsp_valid !== 1'b0) begin
      fails++; $display("FAIL busy_lo got req_ready=%b rsp_valid=%b want 0 0", bus.req_ready, bus.rsp_valid);
    end
    @(negedge clk);
    lat = 2;
    tests++;
    if (bus.alu_op !== ((op == OP_ADD) ? 4'd12 : 4'd13) ||
        bus.alu_a !== ((op == OP_NEG) ? 64'd0 : a[127:64]) || bus.alu_b !== b[127:64]) begin
      fails++; $display("FAIL hi_drive got op=%0d a=%h b=%h", bus.alu_op, bus.alu_a, bus.alu_b);
    end
    while (bus.rsp_valid !== 1'b1 && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    tests++;
    if (lat != 3) begin
      fails++; $display("FAIL latency got %0d cycles want 3", lat);
    end
    e = sb.pop_front();
    res = bus.rsp_result;
    flg = bus.rsp_flags;
    tests++;
    if (bus.rsp_result !== e.result) begin
      fails++; $display("FAIL result op=%0d got %h want %h", op, bus.rsp_result, e.result);
    end
    tests++;
    if (bus.rsp_flags !== e.flags) begin
      fails++; $display("FAIL flags op=%0d got %b want %b", op, bus.rsp_flags, e.flags);
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      tests++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== e.result || bus.rsp_flags !== e.flags ||
          bus.req_ready !== 1'b0 || bus.alu_op !== 4'd5) begin
        fails++; $display("FAIL hold cycle %0d got valid=%b res=%h flg=%b ready=%b alu_op=%0d", i,
                          bus.rsp_valid, bus.rsp_result, bus.rsp_flags, bus.req_ready, bus.alu_op);
      end
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    tests++;
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      fails++; $display("FAIL release got rsp_valid=%b req_ready=%b want 0 1", bus.rsp_valid, bus.req_ready);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_op = 2'd0; bus.req_a = '0; bus.req_b = '0; bus.req_flags = '0;
    bus.rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if (bus.req_ready !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.rsp_result !== 128'd0 ||
        bus.rsp_flags !== 8'd0) begin
      fails++; $display("FAIL reset_rsp got ready=%b valid=%b res=%h flg=%h", bus.req_ready,
                        bus.rsp_valid, bus.rsp_result, bus.rsp_flags);
    end
    tests++;
    if (bus.alu_op !== 4'd5 || bus.alu_a !== 64'd0 || bus.alu_b !== 64'd0 || bus.alu_flags_in !== 8'd0) begin
      fails++; $display("FAIL reset_alu got op=%0d a=%h b=%h fi=%h", bus.alu_op, bus.alu_a,
                        bus.alu_b, bus.alu_flags_in);
    end
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (bus.req_ready !== 1'b1) begin
      fails++; $display("FAIL reset_release req_ready got %b want 1", bus.req_ready);
    end
  endtask

  task automatic test_add;
    logic [127:0] r; logic [7:0] f;
    run_txn(OP_ADD, 128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF, 128'd1, 8'h00, 0, r, f);
    tests++;
    if (r !== 128'h0000_0000_0000_0001_0000_0000_0000_0000 || f[1] !== 1'b0 || f[0] !== 1'b0 ||
        f[3] !== 1'b0 || f[4] !== 1'b1) begin
      fails++; $display("FAIL add_carry_chain got res=%h flg=%b", r, f);
    end
  endtask

  task automatic test_sub;
    logic [127:0] r; logic [7:0] f;
    run_txn(OP_SUB, 128'h0000_0000_0000_0001_0000_0000_0000_0000, 128'd1, 8'h00, 0, r, f);
    tests++;
    if (r !== 128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF || f[1] !== 1'b1 || f[5] !== 1'b1 ||
        f[0] !== 1'b0 || f[2] !== 1'b0 || f[4] !== 1'b1) begin
      fails++; $display("FAIL sub_borrow_chain got res=%h flg=%b", r, f);
    end
  endtask

  task automatic test_cmp;
    logic [127:0] r; logic [7:0] f;
    run_txn(OP_CMP, 128'h1234_5678_9ABC_DEF0_0F0F_0F0F_0F0F_0F0F,
            128'h1234_5678_9ABC_DEF0_0F0F_0F0F_0F0F_0F0F, 8'h00, 0, r, f);
    tests++;
    if (r !== 128'd0 || f[0] !== 1'b1 || f[1] !== 1'b1 || f[5] !== 1'b0) begin
      fails++; $display("FAIL cmp_equal got res=%h flg=%b", r, f);
    end
    run_txn(OP_CMP, 128'd0, 128'd1, 8'h20, 0, r, f);
    tests++;
    if (f[1] !== 1'b0 || f[5] !== 1'b0 || f[2] !== 1'b1 || f[0] !== 1'b0) begin
      fails++; $display("FAIL cmp_less got flg=%b", f);
    end
  endtask

  task automatic test_neg;
    logic [127:0] r; logic [7:0] f;
    run_txn(OP_NEG, 128'hDEAD, 128'h8000_0000_0000_0000_0000_0000_0000_0000, 8'h00, 0, r, f);
    tests++;
    if (r !== 128'h8000_0000_0000_0000_0000_0000_0000_0000 || f[3] !== 1'b1 || f[1] !== 1'b1 ||
        f[2] !== 1'b1) begin
      fails++; $display("FAIL neg_min got res=%h flg=%b", r, f);
    end
    run_txn(OP_NEG, 128'h5, 128'd0, 8'h00, 0, r, f);
    tests++;
    if (r !== 128'd0 || f[1] !== 1'b0 || f[0] !== 1'b1) begin
      fails++; $display("FAIL neg_zero got res=%h flg=%b", r, f);
    end
  endtask

  task automatic test_backpressure;
    logic [127:0] r; logic [7:0] f;
    run_txn(OP_ADD, 128'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 128'd1, 8'hC0, 5, r, f);
    tests++;
    if (f[7:6] !== 2'b11 || f[3] !== 1'b1) begin
      fails++; $display("FAIL flags_passthrough got flg=%b want S,I=11 V=1", f);
    end
  endtask

  task automatic test_reset_mid;
    logic [127:0] r; logic [7:0] f;
    int seen;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_op = OP_SUB; bus.req_a = 128'h99; bus.req_b = 128'h11;
    bus.req_flags = 8'h00;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if (bus.alu_op !== 4'd13) begin
      fails++; $display("FAIL mid_in_hi alu_op got %0d want 13", bus.alu_op);
    end
    rst = 1'b1;
    #1;
    tests++;
    if (bus.rsp_valid !== 1'b0 || bus.alu_op !== 4'd5 || bus.req_ready !== 1'b0 ||
        bus.alu_b !== 64'd0) begin
      fails++; $display("FAIL mid_reset got valid=%b alu_op=%0d ready=%b alu_b=%h", bus.rsp_valid,
                        bus.alu_op, bus.req_ready, bus.alu_b);
    end
    @(negedge clk);
    rst = 1'b0;
    bus.rsp_ready = 1'b1;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.rsp_valid === 1'b1) seen++;
    end
    bus.rsp_ready = 1'b0;
    tests++;
    if (seen != 0) begin
      fails++; $display("FAIL abandoned_response got %0d valid cycles want 0", seen);
    end
    run_txn(OP_ADD, 128'd1, 128'd1, 8'h00, 0, r, f);
    tests++;
    if (r !== 128'd2 || f[0] !== 1'b0) begin
      fails++; $display("FAIL after_reset_add got res=%h flg=%b", r, f);
    end
  endtask

  task automatic test_random;
    logic [127:0] a, b, r;
    logic [7:0] f;
    logic [1:0] op;
    for (int i = 0; i < 24; i++) begin
      op = 2'(i % 4);
      a  = {$urandom, $urandom, $urandom, $urandom};
      b  = {$urandom, $urandom, $urandom, $urandom};
      if (i % 5 == 0) b = a;
      if (i % 7 == 0) b[63:0] = a[63:0];
      if (i % 9 == 0) b = 128'd0;
      run_txn(op, a, b, 8'($urandom), 0, r, f);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_add();
    test_sub();
    test_cmp();
    test_neg();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout after %0d tests", tests);
    $fatal(1, "watchdog");
  end

endmodule
